// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding, the
// per-stage control bundle and a width helper for the memory-wait counter.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_clear;
        logic idex_en;
        logic idex_clear;
        logic exmem_en;
        logic exmem_clear;
        logic memwb_en;
        logic memwb_clear;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_clear: 1'b0, idex_en: 1'b1, idex_clear: 1'b0,
        exmem_en: 1'b1, exmem_clear: 1'b0, memwb_en: 1'b1, memwb_clear: 1'b0};

    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_clear: 1'b0, idex_en: 1'b0, idex_clear: 1'b0,
        exmem_en: 1'b0, exmem_clear: 1'b0, memwb_en: 1'b0, memwb_clear: 1'b0};

    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_clear: 1'b1, idex_en: 1'b0, idex_clear: 1'b1,
        exmem_en: 1'b0, exmem_clear: 1'b1, memwb_en: 1'b0, memwb_clear: 1'b1};

    // The wrong-path instructions in IF/ID and ID/EX are squashed.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_clear: 1'b1, idex_en: 1'b1, idex_clear: 1'b1,
        exmem_en: 1'b1, exmem_clear: 1'b0, memwb_en: 1'b1, memwb_clear: 1'b0};

    // PC and IF/ID hold; a bubble enters ID/EX while the load moves on.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_clear: 1'b0, idex_en: 1'b1, idex_clear: 1'b1,
        exmem_en: 1'b1, exmem_clear: 1'b0, memwb_en: 1'b1, memwb_clear: 1'b0};

    // Smallest width w with 2^w > max_val.
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        int unsigned w;
        w = 32'd1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= max_val) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-sequencer bundle: hazard sources from the pipeline in, stage
// controls out. Performance counters appear only with HAZARD_PERF_EN.
interface pipe_hazard_ctrl_if;
    logic       ex_MemRead;
    logic [4:0] ex_rdidx;
    logic [4:0] id_R1idx;
    logic [4:0] id_R2idx;
    logic       id_use_r1;
    logic       id_use_r2;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       dbg_halt;
    logic       dbg_step;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_clear;
    logic       idex_en;
    logic       idex_clear;
    logic       exmem_en;
    logic       exmem_clear;
    logic       memwb_en;
    logic       memwb_clear;
    logic [1:0] state_o;
    logic       mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_ldstall;
    logic [31:0] perf_flush;
    logic [31:0] perf_memwait;
    logic [31:0] perf_cycles;
`endif

    modport master (
        output ex_MemRead, ex_rdidx, id_R1idx, id_R2idx, id_use_r1, id_use_r2,
               ex_redirect, mem_req, mem_ready, dbg_halt, dbg_step,
        input  pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en,
               exmem_clear, memwb_en, memwb_clear, state_o, mem_err
`ifdef HAZARD_PERF_EN
        , input perf_ldstall, perf_flush, perf_memwait, perf_cycles
`endif
    );

    modport slave (
        input  ex_MemRead, ex_rdidx, id_R1idx, id_R2idx, id_use_r1, id_use_r2,
               ex_redirect, mem_req, mem_ready, dbg_halt, dbg_step,
        output pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en,
               exmem_clear, memwb_en, memwb_clear, state_o, mem_err
`ifdef HAZARD_PERF_EN
        , output perf_ldstall, perf_flush, perf_memwait, perf_cycles
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the source registers of ID.
// Purely combinational so the forwarding unit can reuse it.
module pipe_hazard_ctrl_hazard_detect (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rdidx_i,
    input  logic [4:0] id_r1idx_i,
    input  logic [4:0] id_r2idx_i,
    input  logic       id_use_r1_i,
    input  logic       id_use_r2_i,
    output logic       load_use_o
);
    logic r1_hit_s;
    logic r2_hit_s;

    assign r1_hit_s   = id_use_r1_i && (id_r1idx_i == ex_rdidx_i);
    assign r2_hit_s   = id_use_r2_i && (id_r2idx_i == ex_rdidx_i);
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use_o = ex_mem_read_i && (ex_rdidx_i != 5'd0) && (r1_hit_s || r2_hit_s);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enable/clear from load-use, EX redirect,
// memory wait and debug halt/step. Optional counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = cnt_bits(MEM_TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             halt_pend_q, halt_pend_d;

    logic       load_use_s;
    logic       mem_stall_s;
    pipe_ctrl_t run_ctrl_s;
    pipe_ctrl_t ctrl_s;
    pipe_ctrl_t out_s;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .ex_mem_read_i (bus.ex_MemRead),
        .ex_rdidx_i    (bus.ex_rdidx),
        .id_r1idx_i    (bus.id_R1idx),
        .id_r2idx_i    (bus.id_R2idx),
        .id_use_r1_i   (bus.id_use_r1),
        .id_use_r2_i   (bus.id_use_r2),
        .load_use_o    (load_use_s)
    );

    assign mem_stall_s = bus.mem_req && !bus.mem_ready;

    // Controls for a cycle evaluated as RUN: mem stall > redirect > load-use.
    always_comb begin
        run_ctrl_s = CTRL_RUN;
        if (mem_stall_s) begin
            run_ctrl_s = CTRL_FREEZE;
        end else if (bus.ex_redirect) begin
            run_ctrl_s = CTRL_REDIRECT;
        end else if (load_use_s) begin
            run_ctrl_s = CTRL_LOAD_USE;
        end else begin
            run_ctrl_s = CTRL_RUN;
        end
    end

    // Next-state, wait counter, timeout flag and pending-halt logic.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        halt_pend_d = halt_pend_q;
        ctrl_s      = CTRL_FREEZE;
        case (state_q)
            ST_RUN, ST_STEP: begin
                ctrl_s = run_ctrl_s;
                if (mem_stall_s) begin
                    state_d     = ST_MEM_WAIT;
                    wait_cnt_d  = CNT_W'(1);
                    halt_pend_d = bus.dbg_halt;
                end else if (bus.dbg_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                end else begin
                    mem_err_d = mem_err_q;
                end
                if (bus.mem_ready) begin
                    ctrl_s      = run_ctrl_s;
                    wait_cnt_d  = '0;
                    halt_pend_d = 1'b0;
                    state_d     = (halt_pend_q || bus.dbg_halt) ? ST_HALT : ST_RUN;
                end else begin
                    ctrl_s      = CTRL_FREEZE;
                    halt_pend_d = halt_pend_q || bus.dbg_halt;
                    if (wait_cnt_q != {CNT_W{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end
            end
            ST_HALT: begin
                ctrl_s = CTRL_FREEZE;
                if (bus.dbg_step) begin
                    state_d = ST_STEP;
                end else if (!bus.dbg_halt) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                ctrl_s  = CTRL_FREEZE;
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset forces every stage cleared regardless of the FSM.
    always_comb begin
        if (rst) begin
            out_s = CTRL_RESET;
        end else begin
            out_s = ctrl_s;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign bus.pc_en       = out_s.pc_en;
    assign bus.ifid_en     = out_s.ifid_en;
    assign bus.ifid_clear  = out_s.ifid_clear;
    assign bus.idex_en     = out_s.idex_en;
    assign bus.idex_clear  = out_s.idex_clear;
    assign bus.exmem_en    = out_s.exmem_en;
    assign bus.exmem_clear = out_s.exmem_clear;
    assign bus.memwb_en    = out_s.memwb_en;
    assign bus.memwb_clear = out_s.memwb_clear;
    assign bus.state_o     = state_q;
    assign bus.mem_err     = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic        run_eval_s;
    logic [31:0] perf_ldstall_q, perf_flush_q, perf_memwait_q, perf_cycles_q;

    assign run_eval_s = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                        ((state_q == ST_MEM_WAIT) && bus.mem_ready);

    // Event counters; all wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ldstall_q <= 32'd0;
            perf_flush_q   <= 32'd0;
            perf_memwait_q <= 32'd0;
            perf_cycles_q  <= 32'd0;
        end else begin
            if (run_eval_s && !mem_stall_s && !bus.ex_redirect && load_use_s) begin
                perf_ldstall_q <= perf_ldstall_q + 32'd1;
            end
            if (run_eval_s && !mem_stall_s && bus.ex_redirect) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if (state_q == ST_MEM_WAIT) begin
                perf_memwait_q <= perf_memwait_q + 32'd1;
            end
            if (state_q != ST_HALT) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
        end
    end

    assign bus.perf_ldstall = perf_ldstall_q;
    assign bus.perf_flush   = perf_flush_q;
    assign bus.perf_memwait = perf_memwait_q;
    assign bus.perf_cycles  = perf_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short memory timeout.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Bundle order: pc_en, ifid en/clr, idex en/clr, exmem en/clr, memwb en/clr.
    localparam logic [8:0] E_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] E_FREEZE = 9'b0_00_00_00_00;
    localparam logic [8:0] E_RESET  = 9'b0_01_01_01_01;
    localparam logic [8:0] E_LDUSE  = 9'b0_00_11_10_10;
    localparam logic [8:0] E_REDIR  = 9'b1_11_11_10_10;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_obs();
        return {bus.pc_en, bus.ifid_en, bus.ifid_clear, bus.idex_en, bus.idex_clear,
                bus.exmem_en, bus.exmem_clear, bus.memwb_en, bus.memwb_clear};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%b expected=%b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, check controls and state, then advance.
    task automatic step_chk(input string tag, input logic [8:0] exp_ctrl, input logic [1:0] exp_st);
        #1;
        chk({tag, ".ctrl"}, ctrl_obs(), exp_ctrl);
        chk({tag, ".state"}, {7'd0, bus.state_o}, {7'd0, exp_st});
        tick();
    endtask

    task automatic clear_inputs();
        bus.ex_MemRead  = 1'b0;
        bus.ex_rdidx    = 5'd0;
        bus.id_R1idx    = 5'd0;
        bus.id_R2idx    = 5'd0;
        bus.id_use_r1   = 1'b0;
        bus.id_use_r2   = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.dbg_halt    = 1'b0;
        bus.dbg_step    = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("rst.ctrl", ctrl_obs(), E_RESET);
        chk("rst.state", {7'd0, bus.state_o}, 9'd0);
        chk("rst.err", {8'd0, bus.mem_err}, 9'd0);
        rst = 1'b0;
        step_chk("idle", E_RUN, 2'd0);

        // Load-use on rs1, then the load has moved on.
        bus.ex_MemRead = 1'b1; bus.ex_rdidx = 5'd5; bus.id_R1idx = 5'd5; bus.id_use_r1 = 1'b1;
        step_chk("lu_r1", E_LDUSE, 2'd0);
        bus.ex_MemRead = 1'b0;
        step_chk("lu_done", E_RUN, 2'd0);
        // Load-use on rs2 only, then rs2 not read.
        bus.ex_MemRead = 1'b1; bus.ex_rdidx = 5'd7; bus.id_R2idx = 5'd7;
        bus.id_use_r2 = 1'b1; bus.id_use_r1 = 1'b0;
        step_chk("lu_r2", E_LDUSE, 2'd0);
        bus.id_use_r2 = 1'b0;
        step_chk("lu_r2_unused", E_RUN, 2'd0);
        // Load to x0 never stalls.
        bus.ex_rdidx = 5'd0; bus.id_R1idx = 5'd0; bus.id_use_r1 = 1'b1;
        step_chk("lu_x0", E_RUN, 2'd0);
        // Redirect overrides a simultaneous load-use.
        bus.ex_rdidx = 5'd5; bus.id_R1idx = 5'd5; bus.ex_redirect = 1'b1;
        step_chk("redir_lu", E_REDIR, 2'd0);
        clear_inputs();

        // Three-cycle memory wait, ready returns RUN controls in that cycle.
        bus.mem_req = 1'b1;
        step_chk("mw0", E_FREEZE, 2'd0);
        step_chk("mw1", E_FREEZE, 2'd1);
        step_chk("mw2", E_FREEZE, 2'd1);
        bus.mem_ready = 1'b1;
        step_chk("mw_ready", E_RUN, 2'd1);
        clear_inputs();
        step_chk("mw_after", E_RUN, 2'd0);
        chk("mw.err", {8'd0, bus.mem_err}, 9'd0);

        // Halt, single step, halt again, resume.
        bus.dbg_halt = 1'b1;
        step_chk("halt_req", E_RUN, 2'd0);
        step_chk("halted", E_FREEZE, 2'd2);
        bus.dbg_step = 1'b1;
        step_chk("step_req", E_FREEZE, 2'd2);
        bus.dbg_step = 1'b0;
        step_chk("stepping", E_RUN, 2'd3);
        step_chk("rehalted", E_FREEZE, 2'd2);
        bus.dbg_halt = 1'b0;
        step_chk("resume_req", E_FREEZE, 2'd2);
        step_chk("resumed", E_RUN, 2'd0);

        // Timeout: error rises after the 4th wait cycle and stays set.
        bus.mem_req = 1'b1;
        step_chk("to0", E_FREEZE, 2'd0);
        step_chk("to1", E_FREEZE, 2'd1);
        step_chk("to2", E_FREEZE, 2'd1);
        step_chk("to3", E_FREEZE, 2'd1);
        chk("to4.err_low", {8'd0, bus.mem_err}, 9'd0);
        step_chk("to4", E_FREEZE, 2'd1);
        chk("to5.err_high", {8'd0, bus.mem_err}, 9'd1);
        step_chk("to5", E_FREEZE, 2'd1);
        bus.mem_ready = 1'b1;
        step_chk("to_ready", E_RUN, 2'd1);
        clear_inputs();
        step_chk("to_after", E_RUN, 2'd0);
        chk("to.err_sticky", {8'd0, bus.mem_err}, 9'd1);

        // Halt requested briefly during a wait is honoured on exit.
        bus.mem_req = 1'b1;
        step_chk("hp0", E_FREEZE, 2'd0);
        bus.dbg_halt = 1'b1;
        step_chk("hp1", E_FREEZE, 2'd1);
        bus.dbg_halt = 1'b0;
        step_chk("hp2", E_FREEZE, 2'd1);
        bus.mem_ready = 1'b1;
        step_chk("hp_ready", E_RUN, 2'd1);
        clear_inputs();
        step_chk("hp_halted", E_FREEZE, 2'd2);
        step_chk("hp_resume", E_RUN, 2'd0);

        // Asynchronous reset in the middle of a wait.
        bus.mem_req = 1'b1;
        step_chk("ar0", E_FREEZE, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.ctrl", ctrl_obs(), E_RESET);
        chk("ar.state", {7'd0, bus.state_o}, 9'd0);
        chk("ar.err", {8'd0, bus.mem_err}, 9'd0);
        tick();
        rst = 1'b0;
        clear_inputs();
        step_chk("ar_after", E_RUN, 2'd0);
        step_chk("ar_idle", E_RUN, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates the per-stage enable/clear pairs from three sources: load-use hazards, taken branch/jump in EX, and a multi-cycle data-memory handshake.
- Also supports a debug halt/single-step, with a timeout watchdog on memory waits.

Parameters:
- MEM_TIMEOUT, 255: max consecutive wait cycles before mem_err is set.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_MemRead  in  1  instruction in EX is a load.
- ex_rdidx  in  5  destination register of the EX instruction.
- id_R1idx  in  5  rs1 index of the ID instruction.
- id_R2idx  in  5  rs2 index of the ID instruction.
- id_use_r1  in  1  ID instruction reads rs1.
- id_use_r2  in  1  ID instruction reads rs2.
- ex_redirect  in  1  EX resolves a taken branch or jump.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- dbg_halt  in  1  level; freeze the pipeline while high.
- dbg_step  in  1  one-cycle pulse; advance one cycle while halted.
- pc_en  out  1  PC update enable.
- ifid_en, ifid_clear  out  1 each  IF/ID register controls.
- idex_en, idex_clear  out  1 each  ID/EX register controls.
- exmem_en, exmem_clear  out  1 each  EX/MEM register controls.
- memwb_en, memwb_clear  out  1 each  MEM/WB register controls.
- state_o  out  2  current FSM state, for debug display.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Outputs are combinational (Mealy) from state and inputs; all state is registered.
- Every pipeline register treats clear as higher priority than enable. This block therefore never asserts a clear in any cycle where that stage is frozen.
- While rst is high: state=RUN, wait_cnt=0, mem_err=0, all *_en=0, all *_clear=1.
- States: RUN=0, MEM_WAIT=1, HALT=2, STEP=3.
- Default (RUN, no event): all *_en=1, all *_clear=0.
- mem_stall = mem_req & ~mem_ready.
- load_use = ex_MemRead & (ex_rdidx!=0) & ((id_use_r1 & id_R1idx==ex_rdidx) | (id_use_r2 & id_R2idx==ex_rdidx)).
- Priority in RUN/STEP: mem_stall > ex_redirect > load_use.
  - mem_stall: all *_en=0, all clears=0; next state MEM_WAIT (from RUN and STEP alike); wait_cnt<=1.
  - ex_redirect: pc_en=1 (loads target), ifid_clear=1, idex_clear=1, remaining stages enabled. Load-use is ignored because the ID instruction is wrong-path.
  - load_use: pc_en=0, ifid_en=0, idex_clear=1 (bubble), exmem/memwb enabled. Stalls exactly one cycle, since the load then moves to MEM.
- MEM_WAIT:
  - All *_en=0, clears=0; wait_cnt increments and saturates at 2^CNT_W-1.
  - When wait_cnt==MEM_TIMEOUT, mem_err<=1 (sticky until rst); waiting continues.
  - When mem_ready=1: outputs are evaluated as RUN in that same cycle (redirect/load-use apply), wait_cnt<=0.
  - Next state on mem_ready: HALT if halt_pend, else RUN.
- Halt:
  - dbg_halt sampled in RUN with no mem_stall: the current cycle completes normally, next state HALT.
  - dbg_halt during MEM_WAIT sets halt_pend; it is honoured on exit.
- HALT: all *_en=0, clears=0.
  - dbg_step=1 -> STEP.
  - dbg_halt=0 -> RUN.
  - Both asserted together: step takes priority.
- STEP: exactly one cycle evaluated as RUN. Next state MEM_WAIT if mem_stall, else HALT if dbg_halt, else RUN.
- Async reset mid-MEM_WAIT or mid-HALT returns to RUN, clearing halt_pend, wait_cnt and mem_err.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds four 32-bit outputs, each reset to 0 and wrapping at 2^32:
  - perf_ldstall: counts load-use stall cycles.
  - perf_flush: counts redirect cycles.
  - perf_memwait: counts MEM_WAIT cycles.
  - perf_cycles: counts cycles not in HALT.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package: state encodings, clog2-style helper for CNT_W, and a pipeline-control bundle typedef (pc_en plus 4 en/clear pairs).
- One natural sub-module: hazard_detect (combinational load_use compare), reusable by the forwarding unit.

Test Plan:
- Load-use: ex_MemRead=1, ex_rdidx=5, id_R1idx=5, id_use_r1=1 -> one cycle pc_en=0, ifid_en=0, idex_clear=1. With ex_rdidx=0 there is no stall.
- Redirect with simultaneous load_use -> pc_en=1, ifid_clear=1, idex_clear=1, ifid_en=1.
- mem_req=1, mem_ready low for 3 cycles -> all en=0 and no clears for 3 cycles, state_o=1. When ready is raised, outputs return to RUN values in that cycle.
- MEM_TIMEOUT=4, ready never raised -> mem_err rises after the 4th wait cycle and stays high until rst pulse.
- Halt then step: dbg_halt=1 -> state_o=2 with en=0. dbg_step pulse -> exactly one cycle all en=1, then state_o=2 again.
- Async rst asserted mid-MEM_WAIT -> immediately state_o=0 and all clears=1. After release, RUN defaults apply.
